inner_fn_batch_ctrl: RTL and testbench

Batch scheduler for the pipelined inner-function datapath, which computes 0.5*x + x^2*cos((x-128)/128). On a `start` command it streams `count` single-precision samples from an input on-chip RAM into the datapath, one per cycle. It tracks in-flight samples with a token shift register matched to the datapath latency and writes each result to an output RAM at the same offset. It then pulses `done`, and supports whole-block stalling from the output side.

---
 rtl/inner_fn_batch_ctrl_if.sv | 40 ++++
 rtl/inner_fn_batch_ctrl.sv | 90 +++++++++
 tb/tb_inner_fn_batch_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/inner_fn_batch_ctrl_if.sv
// Command, RAM and datapath signals of the inner-function batch scheduler.
// master = scheduler side, slave = environment side.
interface inner_fn_batch_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
);
    logic              start;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] base_in;
    logic [ADDR_W-1:0] base_out;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              pipe_en;
    logic              pipe_aclr;
    logic [31:0]       pipe_data;
    logic [31:0]       pipe_result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        input  start, count, base_in, base_out, out_ready,
        input  rd_data, pipe_result,
        output busy, done, rd_en, rd_addr,
        output pipe_en, pipe_aclr, pipe_data,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, count, base_in, base_out, out_ready,
        output rd_data, pipe_result,
        input  busy, done, rd_en, rd_addr,
        input  pipe_en, pipe_aclr, pipe_data,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inner_fn_batch_ctrl.sv
// Batch scheduler: streams samples from input RAM through the datapath
// and retires results to output RAM using a latency-matched token line.
module inner_fn_batch_ctrl #(
    parameter int PIPE_LATENCY = 43,
    parameter int ADDR_W       = 10,
    parameter int CNT_W        = 11
) (
    input  logic                 clk,
    input  logic                 reset_n,
    inner_fn_batch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    issued_q;
    logic [CNT_W-1:0]    retired_q;
    logic [ADDR_W-1:0]   base_in_q;
    logic [ADDR_W-1:0]   base_out_q;
    logic [PIPE_LATENCY:0] tok_q;

    logic             pipe_en;
    logic             rd_en;
    logic             wr_en;
    logic [CNT_W-1:0] issued_d;
    logic [CNT_W-1:0] retired_d;

    // Everything freezes together when the output side stalls.
    assign pipe_en = reset_n & bus.out_ready
                   & ((state_q == RUN) | (state_q == DRAIN));
    assign rd_en   = pipe_en & (state_q == RUN);
    assign wr_en   = pipe_en & tok_q[PIPE_LATENCY];

    assign issued_d  = issued_q + CNT_W'(1);
    assign retired_d = retired_q + CNT_W'(wr_en);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            base_in_q  <= '0;
            base_out_q <= '0;
            tok_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q      <= bus.count;
                        base_in_q  <= bus.base_in;
                        base_out_q <= bus.base_out;
                        issued_q   <= '0;
                        retired_q  <= '0;
                        tok_q      <= '0;
                        state_q    <= (bus.count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (bus.out_ready) begin
                        issued_q  <= issued_d;
                        retired_q <= retired_d;
                        tok_q     <= {tok_q[PIPE_LATENCY-1:0], 1'b1};
                        if (issued_d == cnt_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        retired_q <= retired_d;
                        tok_q     <= {tok_q[PIPE_LATENCY-1:0], 1'b0};
                        if (retired_d == cnt_q) state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = reset_n & (state_q != IDLE);
    assign bus.done      = reset_n & (state_q == DONE);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = reset_n ? base_in_q + issued_q[ADDR_W-1:0] : '0;
    assign bus.pipe_en   = pipe_en;
    assign bus.pipe_aclr = ~reset_n;
    assign bus.pipe_data = bus.rd_data;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = reset_n ? base_out_q + retired_q[ADDR_W-1:0] : '0;
    assign bus.wr_data   = bus.pipe_result;
endmodule

// File: tb/tb_inner_fn_batch_ctrl.sv
// Bench for inner_fn_batch_ctrl: RAM and datapath stand-ins plus a
// per-batch reference of read/write order, data and event timing.
module tb_inner_fn_batch_ctrl;
    localparam int L  = 43;
    localparam int AW = 10;
    localparam int CW = 11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   s1 = 0, l1 = 0, s2 = 0, l2 = 0;

    logic [31:0] iram [1024];
    logic [31:0] dp_q [L];

    inner_fn_batch_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    inner_fn_batch_ctrl #(
        .PIPE_LATENCY(L), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: any fixed function, L-stage pipe with clk_en
    function automatic logic [31:0] dp_f(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ (x * 32'd2654435761) ^ 32'h3C6E_F372;
    endfunction

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= iram[bus.rd_addr];

    always @(posedge clk) begin
        if (bus.pipe_aclr) begin
            for (int i = 0; i < L; i++) dp_q[i] <= '0;
        end else if (bus.pipe_en) begin
            for (int i = L - 1; i > 0; i--) dp_q[i] <= dp_q[i-1];
            dp_q[0] <= dp_f(bus.pipe_data);
        end
    end
    assign bus.pipe_result = dp_q[L-1];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic bit stalled(input int rel);
        return (rel >= s1 && rel < s1 + l1) || (rel >= s2 && rel < s2 + l2);
    endfunction

    function automatic int stalls_before(input int t);
        int s = 0;
        for (int c = 1; c < t; c++) if (stalled(c)) s++;
        return s;
    endfunction

    // Each stalled cycle delays every later event by one cycle, so
    // eff = cycle minus earlier stalls must match the unstalled timeline.
    task automatic run_batch(input int n, input logic [9:0] bi,
                             input logic [9:0] bo, input int dup_at);
        int rel, eff, S, nrd, nwr, busy_bad;
        bit fin;
        logic [9:0] a;
        nrd = 0; nwr = 0; busy_bad = 0; fin = 0;
        @(posedge clk); #1;
        S = cyc;
        bus.start = 1'b1;
        bus.count = CW'(n);
        bus.base_in = bi;
        bus.base_out = bo;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("busy_c0", 32'(bus.busy), 0);
        for (int k = 0; k < n + L + 40 && !fin; k++) begin
            @(posedge clk); #1;
            rel = cyc - S;
            bus.out_ready = !stalled(rel);
            bus.start = (rel == dup_at);
            if (rel == dup_at) begin
                bus.count = CW'(n + 7);
                bus.base_in = bi ^ 10'h155;
                bus.base_out = bo ^ 10'h2AA;
            end
            @(negedge clk);
            eff = rel - stalls_before(rel);
            if (rel == 1) check("busy_c1", 32'(bus.busy), 1);
            if (!bus.busy) busy_bad++;
            if (bus.rd_en) begin
                a = bi + 10'(nrd);
                check("rd_addr", 32'(bus.rd_addr), 32'(a));
                check("rd_cyc", eff, 1 + nrd);
                nrd++;
            end
            if (bus.wr_en) begin
                a = bo + 10'(nwr);
                check("wr_addr", 32'(bus.wr_addr), 32'(a));
                a = bi + 10'(nwr);
                check("wr_data", bus.wr_data, dp_f(iram[a]));
                check("wr_cyc", eff, L + 2 + nwr);
                nwr++;
            end
            if (bus.done) begin
                check("done_cyc", eff, (n == 0) ? 1 : n + L + 2);
                fin = 1;
            end
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        check("timeout", 32'(fin), 1);
        check("n_rd", nrd, n);
        check("n_wr", nwr, n);
        check("busy_span", busy_bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aclr"}, 32'(bus.pipe_aclr), 1);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_rd_en"}, 32'(bus.rd_en), 0);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        check({tag, "_pipe_en"}, 32'(bus.pipe_en), 0);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    endtask

    initial begin
        int S, rel, stray, n;
        bus.start = 1'b0;
        bus.count = '0;
        bus.base_in = '0;
        bus.base_out = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) iram[i] = $urandom;
        iram[10'h10] = 32'h3F80_0000;
        iram[10'h11] = 32'h4000_0000;
        iram[10'h12] = 32'h4300_0000;
        iram[10'h13] = 32'h0000_0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("aclr_off", 32'(bus.pipe_aclr), 0);

        run_batch(4, 10'h010, 10'h080, 0);
        run_batch(0, 10'h000, 10'h000, 0);
        s1 = 4; l1 = 3; s2 = 30; l2 = 2;
        run_batch(8, 10'h050, 10'h150, 0);
        s1 = 0; l1 = 0; s2 = 0; l2 = 0;
        run_batch(6, 10'h020, 10'h100, 5);
        run_batch(3, 10'h0A0, 10'h1A0, 0);
        run_batch(4, 10'h3FD, 10'h3FE, 0);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 80);
            s1 = $urandom_range(1, n + 2);
            l1 = $urandom_range(0, 3);
            s2 = $urandom_range(n + 3, n + L);
            l2 = $urandom_range(0, 3);
            run_batch(n, 10'($urandom), 10'($urandom), 0);
        end
        s1 = 0; l1 = 0; s2 = 0; l2 = 0;

        @(posedge clk); #1;
        S = cyc;
        bus.start = 1'b1;
        bus.count = CW'(16);
        bus.base_in = 10'h040;
        bus.base_out = 10'h200;
        rel = 0;
        while (rel < 20) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            rel = cyc - S;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("rst_mid2");
        @(posedge clk); #1;
        reset_n = 1'b1;
        stray = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.wr_en || bus.rd_en || bus.busy) stray++;
        end
        check("post_rst_quiet", stray, 0);
        run_batch(2, 10'h300, 10'h010, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
